// File: rtl/ber_accumulator_pkg.sv
// Shared definitions for the BER accumulator: FSM encoding, per-word constants
// and the per-word error clamp.
package ber_accumulator_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WAIT_LOCK = 2'd1;
  localparam state_t ST_RUN       = 2'd2;
  localparam state_t ST_DONE      = 2'd3;

  localparam int BITS_PER_WORD = 8;
  localparam int MAX_WORD_ERR  = 8;

  // A checker word cannot hold more than 8 bit errors; anything larger is clamped.
  function automatic logic [3:0] clamp_word_err(input logic [8:0] err_num);
    return (err_num > 9'(MAX_WORD_ERR)) ? 4'(MAX_WORD_ERR) : err_num[3:0];
  endfunction

endpackage

// File: rtl/ber_accumulator_if.sv
// Control/status bundle between the PRBS checker side and the BER accumulator.
interface ber_accumulator_if #(
  parameter int BIT_CNT_W  = 48,
  parameter int ERR_CNT_W  = 40,
  parameter int LOSS_CNT_W = 16
);
  logic                  en;
  logic [8:0]            err_num;
  logic                  lock;
  logic                  start;
  logic                  stop;
  logic [31:0]           win_words;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [ERR_CNT_W-1:0]  err_cnt;
  logic [LOSS_CNT_W-1:0] loss_cnt;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic                  err_sat;

  modport master (
    output en, err_num, lock, start, stop, win_words,
    input  bit_cnt, err_cnt, loss_cnt, busy, done, timeout, err_sat
  );

  modport slave (
    input  en, err_num, lock, start, stop, win_words,
    output bit_cnt, err_cnt, loss_cnt, busy, done, timeout, err_sat
  );
endinterface

// File: rtl/ber_accumulator_sat_accum.sv
// Saturating accumulator: clear wins over add; sat_o flags an add that lands on
// or would pass the all-ones value.
module sat_accum #(
  parameter int W     = 8,
  parameter int ADD_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [ADD_W-1:0] addend_i,
  output logic [W-1:0]     cnt_o,
  output logic             sat_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (W+1)'(addend_i);
    sat_o = add_i && !clr_i && (sum[W] || (&sum[W-1:0]));
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (add_i)
      cnt_d = sum[W] ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/ber_accumulator.sv
// Gated BER measurement: counts compared bits, bit errors and lock losses over a
// start/stop or fixed-length window, then holds the results for readout.
module ber_accumulator
  import ber_accumulator_pkg::*;
#(
  parameter int BIT_CNT_W  = 48,
  parameter int ERR_CNT_W  = 40,
  parameter int LOSS_CNT_W = 16,
  parameter int LOCK_TMO   = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  ber_accumulator_if.slave   bus
);
  localparam int IDLE_W = $clog2(LOCK_TMO + 1);
  localparam logic [IDLE_W-1:0] TMO_VAL = IDLE_W'(LOCK_TMO);

  state_t            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
  logic              lock_prev_q, lock_prev_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              err_sat_q, err_sat_d;
  logic              clr, add_word, add_loss;
  logic              sat_bit, sat_err, sat_loss;
  logic              locked_word, unlocked_word;

  assign locked_word   = bus.en && bus.lock;
  assign unlocked_word = bus.en && !bus.lock;
  assign idle_inc      = idle_q + IDLE_W'(1);

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idle_d      = idle_q;
    timeout_d   = timeout_q;
    err_sat_d   = err_sat_q;
    clr         = 1'b0;
    add_word    = 1'b0;
    add_loss    = 1'b0;
    lock_prev_d = bus.en ? bus.lock : lock_prev_q;

    if (bus.start) begin
      clr       = 1'b1;
      state_d   = ST_WAIT_LOCK;
      word_d    = '0;
      idle_d    = '0;
      timeout_d = 1'b0;
      err_sat_d = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          // The first locked word only opens the run; its checker data is stale.
          if (locked_word) begin
            state_d = ST_RUN;
            idle_d  = '0;
          end else if (unlocked_word) begin
            idle_d = idle_inc;
            if (idle_inc == TMO_VAL) begin
              state_d   = ST_DONE;
              timeout_d = 1'b1;
            end
          end
          if (bus.stop) state_d = ST_DONE;
        end
        ST_RUN: begin
          if (locked_word) begin
            add_word = 1'b1;
            word_d   = word_q + 32'd1;
            idle_d   = '0;
            if (bus.err_num > 9'(MAX_WORD_ERR)) err_sat_d = 1'b1;
            if ((bus.win_words != '0) && ((word_q + 32'd1) == bus.win_words))
              state_d = ST_DONE;
          end else if (unlocked_word) begin
            idle_d   = idle_inc;
            add_loss = lock_prev_q;
            if (idle_inc == TMO_VAL) begin
              state_d   = ST_DONE;
              timeout_d = 1'b1;
            end
          end
          if (bus.stop) state_d = ST_DONE;
        end
        default: ;
      endcase
    end

    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_sat_q <= err_sat_d | sat_bit | sat_err | sat_loss;
    end
  end

  always_ff @(posedge clk) begin
    word_q      <= word_d;
    idle_q      <= idle_d;
    lock_prev_q <= lock_prev_d;
  end

  sat_accum #(.W(BIT_CNT_W), .ADD_W(4)) u_bit_acc (
    .clk(clk), .reset_n(reset_n), .clr_i(clr), .add_i(add_word),
    .addend_i(4'(BITS_PER_WORD)), .cnt_o(bus.bit_cnt), .sat_o(sat_bit)
  );

  sat_accum #(.W(ERR_CNT_W), .ADD_W(4)) u_err_acc (
    .clk(clk), .reset_n(reset_n), .clr_i(clr), .add_i(add_word),
    .addend_i(clamp_word_err(bus.err_num)), .cnt_o(bus.err_cnt), .sat_o(sat_err)
  );

  sat_accum #(.W(LOSS_CNT_W), .ADD_W(1)) u_loss_acc (
    .clk(clk), .reset_n(reset_n), .clr_i(clr), .add_i(add_loss),
    .addend_i(1'b1), .cnt_o(bus.loss_cnt), .sat_o(sat_loss)
  );

  assign bus.busy    = (state_q == ST_WAIT_LOCK) || (state_q == ST_RUN);
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.err_sat = err_sat_q;
endmodule

// File: tb/tb_ber_accumulator.sv
// Directed bench for ber_accumulator: a full-width instance plus an 8-bit
// bit-counter instance fed the same stimulus for the saturation case.
module tb_ber_accumulator;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        en, lock, start, stop;
  logic [8:0]  err_num;
  logic [31:0] win_words;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ber_accumulator_if #(.BIT_CNT_W(48), .ERR_CNT_W(40), .LOSS_CNT_W(16)) ifa ();
  ber_accumulator_if #(.BIT_CNT_W(8),  .ERR_CNT_W(40), .LOSS_CNT_W(16)) ifb ();

  assign ifa.en = en;   assign ifa.err_num = err_num; assign ifa.lock = lock;
  assign ifa.start = start; assign ifa.stop = stop;   assign ifa.win_words = win_words;
  assign ifb.en = en;   assign ifb.err_num = err_num; assign ifb.lock = lock;
  assign ifb.start = start; assign ifb.stop = stop;   assign ifb.win_words = win_words;

  ber_accumulator #(.BIT_CNT_W(48), .ERR_CNT_W(40), .LOSS_CNT_W(16), .LOCK_TMO(1024)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
  );
  ber_accumulator #(.BIT_CNT_W(8), .ERR_CNT_W(40), .LOSS_CNT_W(16), .LOCK_TMO(1024)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
  );

  typedef struct {
    logic [31:0] win;
    logic [8:0]  eval;
    int          period;
    logic [47:0] exp_bit;
    logic [39:0] exp_err;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic drive(input int cnt, input logic l, input logic [8:0] e);
    en = 1'b1; lock = l; err_num = e;
    repeat (cnt) step();
    en = 1'b0; err_num = '0;
  endtask

  initial begin
    int got;
    vecs[0] = '{32'd100, 9'd0,   0,  48'd800, 40'd0,  1'b0};
    vecs[1] = '{32'd100, 9'd1,   10, 48'd800, 40'd10, 1'b0};
    vecs[2] = '{32'd1,   9'd3,   1,  48'd8,   40'd3,  1'b0};
    vecs[3] = '{32'd5,   9'd9,   1,  48'd40,  40'd40, 1'b1};
    vecs[4] = '{32'd4,   9'd8,   1,  48'd32,  40'd32, 1'b0};
    vecs[5] = '{32'd2,   9'd255, 1,  48'd16,  40'd16, 1'b1};
    vecs[6] = '{32'd3,   9'd2,   2,  48'd24,  40'd2,  1'b0};

    reset_n = 1'b0; en = 1'b0; lock = 1'b0; start = 1'b0; stop = 1'b0;
    err_num = '0; win_words = '0;
    step(); step();
    reset_n = 1'b1;
    step();

    check("rst_bit",     ifa.bit_cnt,  0);
    check("rst_err",     ifa.err_cnt,  0);
    check("rst_loss",    ifa.loss_cnt, 0);
    check("rst_busy",    ifa.busy,     0);
    check("rst_done",    ifa.done,     0);
    check("rst_timeout", ifa.timeout,  0);
    check("rst_err_sat", ifa.err_sat,  0);

    pulse_stop();
    check("idle_stop_busy", ifa.busy, 0);
    check("idle_stop_done", ifa.done, 0);

    // Fixed windows, continuous lock; the word after start carries errors that must be skipped.
    for (int v = 0; v < 7; v++) begin
      win_words = vecs[v].win;
      pulse_start();
      check("win_start_busy", ifa.busy, 1);
      en = 1'b1; lock = 1'b1; got = -1;
      for (int n = 0; n < 300 && got < 0; n++) begin
        if (n == 0)
          err_num = 9'd5;
        else if (vecs[v].period != 0 && (n % vecs[v].period) == 0)
          err_num = vecs[v].eval;
        else
          err_num = '0;
        step();
        if (ifa.done) got = n;
      end
      en = 1'b0; err_num = '0;
      check("win_done_word", 64'(got),      64'(vecs[v].win));
      check("win_bit",       ifa.bit_cnt,   vecs[v].exp_bit);
      check("win_err",       ifa.err_cnt,   vecs[v].exp_err);
      check("win_loss",      ifa.loss_cnt,  0);
      check("win_timeout",   ifa.timeout,   0);
      check("win_err_sat",   ifa.err_sat,   vecs[v].exp_sat);
      check("win_busy",      ifa.busy,      0);
      step();
      check("win_done_pulse", ifa.done,     0);
    end

    // Two lock drops of 5 words each, errors on the unlocked words.
    win_words = 32'd0;
    pulse_start();
    drive(1, 1'b1, 9'd0);
    drive(10, 1'b1, 9'd0);
    drive(5, 1'b0, 9'd3);
    drive(10, 1'b1, 9'd0);
    drive(5, 1'b0, 9'd3);
    drive(10, 1'b1, 9'd0);
    check("loss_busy", ifa.busy, 1);
    pulse_stop();
    check("loss_done", ifa.done,     1);
    check("loss_bit",  ifa.bit_cnt,  240);
    check("loss_err",  ifa.err_cnt,  0);
    check("loss_cnt",  ifa.loss_cnt, 2);
    check("loss_tmo",  ifa.timeout,  0);

    // Never locked: timeout after LOCK_TMO enabled words.
    pulse_start();
    en = 1'b1; lock = 1'b0; got = -1;
    for (int n = 1; n <= 1100 && got < 0; n++) begin
      step();
      if (ifa.done) got = n;
    end
    en = 1'b0;
    check("tmo_words",   64'(got),     1024);
    check("tmo_timeout", ifa.timeout,  1);
    check("tmo_bit",     ifa.bit_cnt,  0);
    check("tmo_loss",    ifa.loss_cnt, 0);
    check("tmo_busy",    ifa.busy,     0);
    pulse_stop();
    check("done_stop_done", ifa.done,  0);
    check("done_stop_tmo",  ifa.timeout, 1);

    // Unbounded run ended by stop, hold, restart, stop sharing a counted word.
    pulse_start();
    drive(1, 1'b1, 9'd0);
    drive(50, 1'b1, 9'd0);
    pulse_stop();
    check("stop_done", ifa.done,    1);
    check("stop_bit",  ifa.bit_cnt, 400);
    drive(5, 1'b1, 9'd1);
    check("hold_bit",  ifa.bit_cnt, 400);
    check("hold_err",  ifa.err_cnt, 0);
    pulse_start();
    check("restart_bit",  ifa.bit_cnt, 0);
    check("restart_tmo",  ifa.timeout, 0);
    check("restart_busy", ifa.busy,    1);
    drive(1, 1'b1, 9'd0);
    drive(3, 1'b1, 9'd0);
    en = 1'b1; lock = 1'b1; err_num = 9'd2; stop = 1'b1;
    step();
    en = 1'b0; err_num = '0; stop = 1'b0;
    check("stop_word_bit",  ifa.bit_cnt, 32);
    check("stop_word_err",  ifa.err_cnt, 2);
    check("stop_word_done", ifa.done,    1);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("both_busy", ifa.busy,    1);
    check("both_done", ifa.done,    0);
    check("both_bit",  ifa.bit_cnt, 0);
    step();
    check("both_done_late", ifa.done, 0);
    drive(1, 1'b1, 9'd0);
    drive(2, 1'b1, 9'd0);
    check("both_run_bit", ifa.bit_cnt, 16);

    // Narrow bit counter saturates; then reset lands mid-run.
    pulse_start();
    drive(1, 1'b1, 9'd0);
    drive(40, 1'b1, 9'd0);
    check("sat_bit_b",  ifb.bit_cnt, 255);
    check("sat_flag_b", ifb.err_sat, 1);
    check("sat_bit_a",  ifa.bit_cnt, 320);
    check("sat_flag_a", ifa.err_sat, 0);
    en = 1'b1; lock = 1'b1; reset_n = 1'b0;
    step();
    reset_n = 1'b1; en = 1'b0;
    check("mid_rst_bit",     ifa.bit_cnt,  0);
    check("mid_rst_err",     ifa.err_cnt,  0);
    check("mid_rst_loss",    ifa.loss_cnt, 0);
    check("mid_rst_busy",    ifa.busy,     0);
    check("mid_rst_done",    ifa.done,     0);
    check("mid_rst_tmo",     ifa.timeout,  0);
    check("mid_rst_err_sat", ifb.err_sat,  0);
    check("mid_rst_bit_b",   ifb.bit_cnt,  0);
    step();
    check("mid_rst_done_late", ifa.done, 0);
    check("mid_rst_busy_late", ifa.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
